// File: rtl/four_bank_mem_pkg.sv
// Shared definitions for the four-bank interleaved memory responder.
// Address split: bank = addr[2:1], row = addr[15:3].
package mem_defs;

  localparam int ADDR_W       = 16;
  localparam int WORD_W       = 16;
  localparam int NUM_BANKS    = 4;
  localparam int BANK_SEL_LSB = 1;
  localparam int BANK_SEL_MSB = 2;
  localparam int ROW_LSB      = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BANK_SEL_MSB-BANK_SEL_LSB:0] bank_t;

  function automatic bank_t bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_SEL_MSB:BANK_SEL_LSB];
  endfunction

endpackage

// File: rtl/four_bank_mem_bank.sv
// One interleave bank: word storage, occupancy counter,
// synchronous write and registered read, both on accept.
module mem_bank
  import mem_defs::*;
#(
  parameter int BANK_AW   = 13,
  parameter int BANK_BUSY = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BANK_AW-1:0] row_i,
  input  word_t              wdata_i,
  input  logic               we_i,
  input  logic               re_i,
  output word_t              rdata_o,
  output logic               busy_o
);

  localparam int CW = 4;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  word_t         mem_q [2**BANK_AW];
  word_t         rdata_q;

  // Reload on accept so the bank stays occupied for BANK_BUSY-1 more cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (we_i || re_i) begin
      cnt_d = CW'(BANK_BUSY - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[row_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[row_i];
    end
  end

  assign busy_o  = (cnt_q != '0);
  assign rdata_o = rdata_q;

endmodule

// File: rtl/four_bank_mem.sv
// Four-way interleaved memory behind the cache fill/writeback port:
// request decode, err/stall, four banks and the fixed-latency read pipe.
module four_bank_mem
  import mem_defs::*;
#(
  parameter int BANK_BUSY = 4,
  parameter int RD_LAT    = 2,
  parameter int BANK_AW   = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    addr,
  input  word_t                data_in,
  input  logic                 wr,
  input  logic                 rd,
  output word_t                data_out,
  output logic                 rd_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  logic               req;
  logic               acc;
  bank_t              bsel;
  logic [BANK_AW-1:0] row;
  word_t              rdata [NUM_BANKS];

  assign bsel  = bank_of(addr);
  assign row   = addr[ROW_LSB +: BANK_AW];
  assign req   = rd | wr;
  assign err   = (rd & wr) | (req & addr[0]);
  assign stall = req & ~err & busy[bsel];
  // Reset beats a same-cycle request.
  assign acc   = req & ~err & ~stall & ~rst;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .BANK_AW  (BANK_AW),
      .BANK_BUSY(BANK_BUSY)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .row_i  (row),
      .wdata_i(data_in),
      .we_i   (acc & wr & (bsel == bank_t'(b))),
      .re_i   (acc & rd & (bsel == bank_t'(b))),
      .rdata_o(rdata[b]),
      .busy_o (busy[b])
    );
  end

  logic  v0_q;
  bank_t b0_q;
  word_t tap0;
  logic  tail_v;
  word_t tail_d;

  // First pipe stage: the bank itself holds the data, we remember which one.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      b0_q <= '0;
    end else begin
      v0_q <= acc & rd;
      b0_q <= bsel;
    end
  end

  assign tap0 = rdata[b0_q];

  if (RD_LAT == 1) begin : g_lat1
    assign tail_v = v0_q;
    assign tail_d = tap0;
  end else begin : g_pipe
    logic [RD_LAT-2:0] v_q;
    word_t             d_q [RD_LAT-1];

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
        for (int k = 0; k < RD_LAT - 1; k++) begin
          d_q[k] <= '0;
        end
      end else begin
        v_q[0] <= v0_q;
        d_q[0] <= tap0;
        for (int k = 1; k < RD_LAT - 1; k++) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
        end
      end
    end

    assign tail_v = v_q[RD_LAT-2];
    assign tail_d = d_q[RD_LAT-2];
  end

  assign rd_valid = tail_v;
  assign data_out = tail_v ? tail_d : '0;

endmodule

// File: tb/tb_four_bank_mem.sv
// Bench for four_bank_mem: two instances (4/2 and 1/4 busy/latency)
// checked every cycle against a cycle-indexed model plus directed literals.
module tb_four_bank_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;

  logic [15:0] dout0, dout1;
  logic        rv0, rv1, st0, st1, er0, er1;
  logic [3:0]  bz0, bz1;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  four_bank_mem u0 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .wr(wr), .rd(rd), .data_out(dout0), .rd_valid(rv0),
    .stall(st0), .busy(bz0), .err(er0)
  );

  four_bank_mem #(.BANK_BUSY(1), .RD_LAT(4), .BANK_AW(13)) u1 (
    .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
    .wr(wr), .rd(rd), .data_out(dout1), .rd_valid(rv1),
    .stall(st1), .busy(bz1), .err(er1)
  );

  // ---------------- model ----------------
  int BB [2] = '{4, 1};
  int RL [2] = '{2, 4};
  int free_at [2][4];
  logic [15:0] mm [int];
  int pend [int];

  task automatic chk(input string nm, input int i,
                     input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL u%0d %s: got %h expected %h", i, nm, got, exp);
    end
  endtask

  initial begin : compare
    logic en;
    int   cyc;
    en  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 2; i++)
      for (int b = 0; b < 4; b++) free_at[i][b] = 0;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        logic [3:0]  eb;
        logic        req, ee, es, erv, acc;
        logic [15:0] ed;
        int          key, b, dv;
        b = int'(addr[2:1]);
        for (int k = 0; k < 4; k++) eb[k] = (cyc < free_at[i][k]);
        req = rd | wr;
        ee  = (rd & wr) | (req & addr[0]);
        es  = req & ~ee & eb[b];
        key = i * 1000000 + cyc;
        erv = pend.exists(key);
        dv  = erv ? pend[key] : 0;
        ed  = (dv < 0) ? 16'h0 : dv[15:0];
        if (en) begin
          chk("stall", i, (i == 0) ? st0 : st1, es);
          chk("err", i, (i == 0) ? er0 : er1, ee);
          chk("busy", i, (i == 0) ? bz0 : bz1, eb);
          chk("rd_valid", i, (i == 0) ? rv0 : rv1, erv);
          if (dv >= 0)
            chk("data_out", i, (i == 0) ? dout0 : dout1, ed);
        end
        if (erv) pend.delete(key);
        acc = req & ~ee & ~es;
        if (rst) begin
          for (int k = 0; k < 4; k++) free_at[i][k] = 0;
          for (int k = 1; k <= RL[i]; k++)
            if (pend.exists(key + k)) pend.delete(key + k);
        end else if (acc) begin
          free_at[i][b] = cyc + BB[i];
          if (wr) mm[i * 65536 + int'(addr)] = data_in;
          if (rd) begin
            if (mm.exists(i * 65536 + int'(addr)))
              pend[key + RL[i]] = int'(mm[i * 65536 + int'(addr)]);
            else
              pend[key + RL[i]] = -1;
          end
        end
      end
      if (rst) en = 1'b1;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input logic r, input logic w,
                     input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; data_in = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drv(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  logic [15:0] wa [4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
  logic [15:0] wd [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] sa [4] = '{16'h0100, 16'h0108, 16'h0110, 16'h0118};
  logic [15:0] sd [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};

  initial begin : stim
    int n;
    rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("reset busy", 0, bz0, 4'h0);
    chk("reset rd_valid", 0, rv0, 1'b0);
    chk("reset data_out", 0, dout0, 16'h0);

    // 1: four consecutive writes across the four banks
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 1'b1, wa[k], wd[k]);
      #3;
      chk("c1 stall", 0, st0, 1'b0);
      if (k == 3) chk("c1 busy at 4th", 0, bz0, 4'h7);
    end
    idle(1);
    #3;
    chk("c1 busy after", 0, bz0, 4'hE);
    idle(3);

    // 2: back-to-back reads, data two cycles after each issue
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drv(1'b1, 1'b0, wa[k], 16'h0);
      else       idle(1);
      #3;
      if (k >= 2) begin
        chk("c2 rd_valid", 0, rv0, 1'b1);
        chk("c2 data", 0, dout0, wd[k-2]);
      end else begin
        chk("c2 early rd_valid", 0, rv0, 1'b0);
      end
    end
    idle(6);

    // 3: read-after-write to the same bank stalls, then returns new data
    drv(1'b0, 1'b1, 16'h0808, 16'hBEEF);
    n = 0;
    drv(1'b1, 1'b0, 16'h0808, 16'h0);
    #3;
    while (st0 && n < 20) begin
      n++;
      drv(1'b1, 1'b0, 16'h0808, 16'h0);
      #3;
    end
    chk("c3 stall cycles", 0, n, 3);
    idle(2);
    #3;
    chk("c3 rd_valid", 0, rv0, 1'b1);
    chk("c3 data", 0, dout0, 16'hBEEF);
    idle(6);

    // 4: illegal requests
    drv(1'b1, 1'b1, 16'h0010, 16'h5555);
    #3;
    chk("c4 err rd&wr", 0, er0, 1'b1);
    chk("c4 stall", 0, st0, 1'b0);
    chk("c4 err rd&wr alt", 1, er1, 1'b1);
    drv(1'b1, 1'b0, 16'h0011, 16'h0);
    #3;
    chk("c4 err odd", 0, er0, 1'b1);
    idle(1);
    #3;
    chk("c4 busy", 0, bz0, 4'h0);
    idle(2);
    #3;
    chk("c4 rd_valid", 0, rv0, 1'b0);
    idle(4);

    // 5: reset drops an in-flight read, storage survives
    drv(1'b1, 1'b0, 16'h0002, 16'h0);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("c5 busy", 0, bz0, 4'h0);
    chk("c5 rd_valid", 0, rv0, 1'b0);
    idle(1);
    #3;
    chk("c5 rd_valid later", 0, rv0, 1'b0);
    drv(1'b1, 1'b0, 16'h0002, 16'h0);
    idle(2);
    #3;
    chk("c5 rd_valid", 0, rv0, 1'b1);
    chk("c5 data kept", 0, dout0, 16'h2222);
    idle(6);

    // 6: same-bank writes and reads on the BANK_BUSY=1, RD_LAT=4 instance
    for (int k = 0; k < 4; k++) begin
      drv(1'b0, 1'b1, sa[k], sd[k]);
      #3;
      chk("c6 wr stall", 1, st1, 1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drv(1'b1, 1'b0, sa[k], 16'h0);
      else       idle(1);
      #3;
      if (k < 4) chk("c6 rd stall", 1, st1, 1'b0);
      if (k >= 4) begin
        chk("c6 rd_valid", 1, rv1, 1'b1);
        chk("c6 data", 1, dout1, sd[k-4]);
      end else begin
        chk("c6 early rd_valid", 1, rv1, 1'b0);
      end
    end
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
